// File: rtl/i2s_audio_tx.sv
// Stereo I2S transmitter: derives MCLK/SCLK/LRCLK from clk and
// serializes buffered 16-bit L/R pairs onto SDIN, 64 slots per frame.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   sample_l, sample_r  16-bit two's-complement sample pair
//   sample_valid/ready  pair handshake (one-entry buffer)
//   underrun            one-clk pulse at a frame start with no new pair
//   mclk, sclk, lrclk   DAC master, bit and word-select clocks
//   sdin                serial data, MSB first, one-slot I2S delay
module i2s_audio_tx #(
    parameter int MCLK_DIV = 2,
    parameter int SCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        underrun,
    output logic        mclk,
    output logic        sclk,
    output logic        lrclk,
    output logic        sdin
);

    localparam int P  = 2 * MCLK_DIV * SCLK_DIV;
    localparam int DW = $clog2(P);
    localparam int MW = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;

    logic [DW-1:0] r_div;
    logic [5:0]    r_slot;
    logic [MW-1:0] r_mcnt;
    logic          r_buf_full;
    logic [15:0]   r_buf_l;
    logic [15:0]   r_buf_r;
    logic [15:0]   r_sh_l;
    logic [15:0]   r_sh_r;
    logic          r_primed;
    logic          r_ready;
    logic          r_underrun;
    logic          r_mclk;
    logic          r_sclk;
    logic          r_lrclk;
    logic          r_sdin;

    logic          w_fs;
    logic          w_acc;
    logic          w_load;
    logic          w_div_wrap;
    logic [DW-1:0] w_div_nx;
    logic [5:0]    w_slot_nx;
    logic          w_mwrap;
    logic [MW-1:0] w_mcnt_nx;
    logic          w_buf_nx;
    logic          w_primed_nx;
    logic [15:0]   w_sh_l_nx;
    logic [15:0]   w_sh_r_nx;
    logic [15:0]   w_word;
    logic [4:0]    w_lo;
    logic [3:0]    w_idx;
    logic          w_sdin_nx;
    logic          w_ur_nx;

    always_comb begin
        w_fs        = (r_div == '0) && (r_slot == 6'd0);
        w_acc       = sample_valid && r_ready;
        w_load      = w_fs && r_buf_full;
        w_div_wrap  = (r_div == DW'(P - 1));
        w_div_nx    = w_div_wrap ? '0 : r_div + DW'(1);
        w_slot_nx   = w_div_wrap ? r_slot + 6'd1 : r_slot;
        w_mwrap     = (r_mcnt == MW'(MCLK_DIV - 1));
        w_mcnt_nx   = w_mwrap ? '0 : r_mcnt + MW'(1);
        // Frame-start unload and a new accept never coincide:
        // an accept needs an empty buffer.
        w_buf_nx    = (r_buf_full && !w_load) || w_acc;
        w_primed_nx = r_primed || w_acc;
        w_sh_l_nx   = w_load ? r_buf_l : r_sh_l;
        w_sh_r_nx   = w_load ? r_buf_r : r_sh_r;
        // Slot 1..16 of each half carries bit 16-slot.
        w_lo        = w_slot_nx[4:0];
        w_idx       = 4'd0 - w_slot_nx[3:0];
        w_word      = w_slot_nx[5] ? w_sh_r_nx : w_sh_l_nx;
        w_sdin_nx   = 1'b0;
        if ((w_lo != 5'd0) && (w_lo <= 5'd16)) begin
            w_sdin_nx = w_word[w_idx];
        end
        // Underrun is flagged in the frame-start cycle itself, so it
        // is judged on the buffer state entering that cycle.
        w_ur_nx = (w_div_nx == '0) && (w_slot_nx == 6'd0) &&
                  !w_buf_nx && w_primed_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_slot     <= '0;
            r_mcnt     <= '0;
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
            r_sh_l     <= '0;
            r_sh_r     <= '0;
            r_primed   <= 1'b0;
            r_ready    <= 1'b0;
            r_underrun <= 1'b0;
            r_mclk     <= 1'b0;
            r_sclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdin     <= 1'b0;
        end else begin
            r_div      <= w_div_nx;
            r_slot     <= w_slot_nx;
            r_mcnt     <= w_mcnt_nx;
            r_buf_full <= w_buf_nx;
            if (w_acc) begin
                r_buf_l <= sample_l;
                r_buf_r <= sample_r;
            end
            r_sh_l     <= w_sh_l_nx;
            r_sh_r     <= w_sh_r_nx;
            r_primed   <= w_primed_nx;
            r_ready    <= ~w_buf_nx;
            r_underrun <= w_ur_nx;
            r_mclk     <= r_mclk ^ w_mwrap;
            r_sclk     <= (w_div_nx >= DW'(P / 2));
            r_lrclk    <= w_slot_nx[5];
            r_sdin     <= w_sdin_nx;
        end
    end

    assign sample_ready = r_ready;
    assign underrun     = r_underrun;
    assign mclk         = r_mclk;
    assign sclk         = r_sclk;
    assign lrclk        = r_lrclk;
    assign sdin         = r_sdin;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: default and (MCLK_DIV=1, SCLK_DIV=2) instances,
// frame-level reference model plus a frame scoreboard on sdin.
module tb_i2s_audio_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        valid [2];
    logic [15:0] sl    [2];
    logic [15:0] sr    [2];
    logic        ready [2];
    logic        ur    [2];
    logic        mclk  [2];
    logic        sclk  [2];
    logic        lrclk [2];
    logic        sdin  [2];

    i2s_audio_tx u_dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .sample_l(sl[0]), .sample_r(sr[0]),
        .sample_valid(valid[0]), .sample_ready(ready[0]),
        .underrun(ur[0]), .mclk(mclk[0]), .sclk(sclk[0]),
        .lrclk(lrclk[0]), .sdin(sdin[0])
    );

    i2s_audio_tx #(.MCLK_DIV(1), .SCLK_DIV(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .sample_l(sl[1]), .sample_r(sr[1]),
        .sample_valid(valid[1]), .sample_ready(ready[1]),
        .underrun(ur[1]), .mclk(mclk[1]), .sclk(sclk[1]),
        .lrclk(lrclk[1]), .sdin(sdin[1])
    );

    function automatic int pm(input int k);
        return (k == 0) ? 2 : 1;
    endfunction
    function automatic int pp(input int k);
        return (k == 0) ? 16 : 4;
    endfunction
    function automatic int pf(input int k);
        return 64 * pp(k);
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    int tmo_req = 0;
    int tmo_seen = 0;

    // reference model state
    bit          alive  [2];
    int          tm     [2];
    bit          pend   [2];
    logic [15:0] pl     [2];
    logic [15:0] pr     [2];
    logic [15:0] cl     [2];
    logic [15:0] cr     [2];
    bit          primed [2];
    bit          er     [2];
    bit          was_up [2];
    logic [31:0] fq0 [$];
    logic [31:0] fq1 [$];

    // per-frame aggregation of the cycle checks
    bit          bad  [2];
    int          ccnt [2];
    int          bcyc [2];
    string       bnm  [2];
    logic        bact [2];
    logic        bexp [2];

    // sdin capture
    logic [63:0] cap   [2];
    int          nb    [2];
    logic        psclk [2];

    task automatic close_ctl(input int k);
        n_tests++;
        if (bad[k]) begin
            n_fail++;
            $display("FAIL ctl%0d.%s cycle %0d: got %b want %b",
                     k, bnm[k], bcyc[k], bact[k], bexp[k]);
        end
        bad[k]  = 0;
        ccnt[k] = 0;
    endtask

    always @(negedge clk) begin
        int pv, fv, ph, slot;
        logic [5:0] ev, av;
        logic [31:0] e;
        logic [63:0] ex;
        string nm [6];
        nm = '{"underrun", "ready", "sdin", "lrclk", "sclk", "mclk"};
        for (int k = 0; k < 2; k++) begin
            pv   = pp(k);
            fv   = 64 * pv;
            ph   = tm[k] % fv;
            slot = ph / pv;
            if (alive[k]) begin
                ev[0] = 1'b0;
                if (ph == 0) begin
                    ev[0] = !pend[k] && primed[k];
                    if (pend[k]) begin
                        cl[k]   = pl[k];
                        cr[k]   = pr[k];
                        pend[k] = 0;
                    end
                    if (k == 0) fq0.push_back({cl[k], cr[k]});
                    else        fq1.push_back({cl[k], cr[k]});
                end
                ev[1] = er[k];
                ev[2] = 1'b0;
                if (slot >= 1 && slot <= 16)
                    ev[2] = cl[k][16 - slot];
                else if (slot >= 33 && slot <= 48)
                    ev[2] = cr[k][48 - slot];
                ev[3] = (slot >= 32);
                ev[4] = ((ph % pv) >= pv / 2);
                ev[5] = (((tm[k] / pm(k)) % 2) == 1);
                av = {mclk[k], sclk[k], lrclk[k], sdin[k], ready[k], ur[k]};
                if (av !== ev && !bad[k]) begin
                    bad[k]  = 1;
                    bcyc[k] = tm[k];
                    for (int i = 5; i >= 0; i--) begin
                        if (av[i] !== ev[i]) begin
                            bnm[k]  = nm[i];
                            bact[k] = av[i];
                            bexp[k] = ev[i];
                        end
                    end
                end
                ccnt[k]++;
                if (ph == fv - 1 || ccnt[k] >= 256 ||
                    (rst_n[k] === 1'b0 && was_up[k]))
                    close_ctl(k);

                if (psclk[k] === 1'b0 && sclk[k] === 1'b1) begin
                    cap[k] = {cap[k][62:0], sdin[k]};
                    nb[k]++;
                    if (nb[k] == 64) begin
                        nb[k] = 0;
                        n_tests++;
                        if ((k == 0 && fq0.size() == 0) ||
                            (k == 1 && fq1.size() == 0)) begin
                            n_fail++;
                            $display("FAIL frame%0d: got %h want no frame",
                                     k, cap[k]);
                        end else begin
                            e  = (k == 0) ? fq0.pop_front() : fq1.pop_front();
                            ex = {1'b0, e[31:16], 15'd0, 1'b0, e[15:0], 15'd0};
                            if (cap[k] !== ex) begin
                                n_fail++;
                                $display("FAIL frame%0d: got %h want %h",
                                         k, cap[k], ex);
                            end
                        end
                    end
                end
                psclk[k] = sclk[k];
            end

            if (rst_n[k] === 1'b0) begin
                alive[k]  = 1;
                tm[k]     = 0;
                pend[k]   = 0;
                primed[k] = 0;
                cl[k]     = '0;
                cr[k]     = '0;
                er[k]     = 0;
                was_up[k] = 0;
                nb[k]     = 0;
                cap[k]    = '0;
                psclk[k]  = 1'b0;
                if (k == 0) fq0.delete();
                else        fq1.delete();
            end else if (alive[k]) begin
                if (valid[k] === 1'b1 && er[k]) begin
                    pend[k]   = 1;
                    pl[k]     = sl[k];
                    pr[k]     = sr[k];
                    primed[k] = 1;
                end
                er[k]     = !pend[k];
                was_up[k] = 1;
                tm[k]++;
            end
        end
        if (tmo_req != tmo_seen) begin
            tmo_seen = tmo_req;
            n_tests++;
            n_fail++;
            $display("FAIL handshake: got no accept, want accept in bound");
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [15:0] l,
                        input logic [15:0] r);
        bit done;
        done  = 0;
        sl[k] = l;
        sr[k] = r;
        valid[k] = 1'b1;
        for (int i = 0; i < 3 * pf(k) && !done; i++) begin
            @(negedge clk);
            if (ready[k] === 1'b1) done = 1;
        end
        if (!done) tmo_req++;
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
        sl[k] = 16'($urandom);
        sr[k] = 16'($urandom);
    endtask

    task automatic wait_phase(input int k, input int ph);
        bit hit;
        hit = 0;
        for (int i = 0; i < pf(k) + 4 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (tm[k] % pf(k) == ph) hit = 1;
        end
        if (!hit) tmo_req++;
    endtask

    task automatic run(input int k);
        int f;
        f = pf(k);
        rst_n[k] = 1'b0;
        cycles(3);
        rst_n[k] = 1'b1;
        cycles(5);
        if (k == 0) send(k, 16'hA5C3, 16'h8001);
        else        send(k, 16'h0001, 16'hFFFF);
        cycles(f * 5 / 2);
        send(k, 16'($urandom), 16'($urandom));
        send(k, 16'($urandom), 16'($urandom));
        cycles(3 * f);
        for (int i = 0; i < 6; i++) begin
            cycles($urandom_range(0, f));
            send(k, 16'($urandom), 16'($urandom));
        end
        cycles(f / 3);
        wait_phase(k, 20 * pp(k));
        rst_n[k] = 1'b0;
        cycles(2);
        rst_n[k] = 1'b1;
        cycles(2 * f + 7);
        send(k, 16'($urandom), 16'($urandom));
        cycles(2 * f + 2 * pp(k));
        rst_n[k] = 1'b0;
        cycles(3);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            valid[k] = 1'b0;
            sl[k]    = '0;
            sr[k]    = '0;
        end
        cycles(4);
        run(0);
        run(1);
        cycles(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
